exe_stage: RTL and testbench

Execute stage of the pipelined MIPS core, sitting directly downstream of the ID/EX pipeline register and feeding the EX/MEM register. It evaluates single-cycle ALU operations and branch conditions combinationally. It runs unsigned MUL and DIVU on an iterative 32-step shift unit, asserting `freeze` to hold the upstream pipeline until the result is ready.

---
 rtl/exe_stage.sv | 194 +++++++++++++++++++
 tb/tb_exe_stage.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage.sv
// +-----------------------------------------------------------------------+
// | exe_stage : MIPS execute stage, ALU/branch plus optional iterative    |
// | MUL/DIVU (enabled by defining EXE_MULDIV_EN).  Rev 1.0                |
// +-----------------------------------------------------------------------+
`default_nettype none

module exe_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] Val1,
  input  logic [WIDTH-1:0] Val2,
  input  logic [WIDTH-1:0] Reg2,
  input  logic [WIDTH-1:0] PC_in,
  input  logic [1:0]       Br_type,
  input  logic [3:0]       EXE_CMD,
  input  logic [4:0]       Dest_in,
  input  logic             MEM_R_EN_in,
  input  logic             MEM_W_EN_in,
  input  logic             WB_EN_in,
  output logic [WIDTH-1:0] ALU_result,
  output logic [WIDTH-1:0] Br_addr,
  output logic             Br_taken,
  output logic             freeze,
  output logic [4:0]       Dest,
  output logic [WIDTH-1:0] Reg2_out,
  output logic             MEM_R_EN,
  output logic             MEM_W_EN,
  output logic             WB_EN
);

  localparam logic [3:0] c_ADD  = 4'b0000;
  localparam logic [3:0] c_SUB  = 4'b0010;
  localparam logic [3:0] c_AND  = 4'b0100;
  localparam logic [3:0] c_OR   = 4'b0101;
  localparam logic [3:0] c_NOR  = 4'b0110;
  localparam logic [3:0] c_XOR  = 4'b0111;
  localparam logic [3:0] c_SLL  = 4'b1000;
  localparam logic [3:0] c_SRA  = 4'b1001;
  localparam logic [3:0] c_SRL  = 4'b1010;
  localparam logic [3:0] c_MUL  = 4'b1100;
  localparam logic [3:0] c_DIVU = 4'b1101;

  logic [WIDTH-1:0] w_alu;
  logic             w_is_muldiv;
  logic             w_br_taken;

  assign w_is_muldiv = (EXE_CMD == c_MUL) || (EXE_CMD == c_DIVU);

  always_comb begin
    w_alu = '0;
    case (EXE_CMD)
      c_ADD:   w_alu = Val1 + Val2;
      c_SUB:   w_alu = Val1 - Val2;
      c_AND:   w_alu = Val1 & Val2;
      c_OR:    w_alu = Val1 | Val2;
      c_NOR:   w_alu = ~(Val1 | Val2);
      c_XOR:   w_alu = Val1 ^ Val2;
      c_SLL:   w_alu = Val1 << Val2[4:0];
      c_SRA:   w_alu = $signed(Val1) >>> Val2[4:0];
      c_SRL:   w_alu = Val1 >> Val2[4:0];
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    w_br_taken = 1'b0;
    if (!w_is_muldiv) begin
      case (Br_type)
        2'b01:   w_br_taken = (Val1 == '0);
        2'b10:   w_br_taken = (Val1 != Reg2);
        2'b11:   w_br_taken = 1'b1;
        default: w_br_taken = 1'b0;
      endcase
    end
  end

  assign Br_taken = w_br_taken;
  assign Br_addr  = PC_in + (Val2 << 2);
  assign Dest     = Dest_in;
  assign Reg2_out = Reg2;

`ifdef EXE_MULDIV_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       count_q, count_d;
  logic [WIDTH-1:0] opa_q, opa_d;   // multiplicand (MUL) or divisor (DIVU)
  logic [WIDTH-1:0] opb_q, opb_d;   // multiplier, or dividend shifting into quotient
  logic [WIDTH-1:0] acc_q, acc_d;   // partial product or remainder
  logic [WIDTH-1:0] res_q, res_d;
  logic             is_div_q, is_div_d;
  logic             w_fsm_freeze;

  logic [WIDTH:0]   w_div_rem;
  logic             w_div_ge;
  logic [WIDTH:0]   w_div_sub;
  logic [WIDTH-1:0] w_step_acc;
  logic [WIDTH-1:0] w_step_opb;

  assign w_div_rem = {acc_q, opb_q[WIDTH-1]};
  assign w_div_ge  = (w_div_rem >= {1'b0, opa_q});
  assign w_div_sub = w_div_rem - {1'b0, opa_q};

  always_comb begin
    if (is_div_q) begin
      w_step_acc = w_div_ge ? w_div_sub[WIDTH-1:0] : w_div_rem[WIDTH-1:0];
      w_step_opb = {opb_q[WIDTH-2:0], w_div_ge};
    end else begin
      w_step_acc = acc_q + (opb_q[0] ? opa_q : '0);
      w_step_opb = opb_q >> 1;
    end
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    acc_d        = acc_q;
    res_d        = res_q;
    is_div_d     = is_div_q;
    w_fsm_freeze = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_is_muldiv) begin
          w_fsm_freeze = 1'b1;
          is_div_d     = (EXE_CMD == c_DIVU);
          opa_d        = (EXE_CMD == c_DIVU) ? Val2 : Val1;
          opb_d        = (EXE_CMD == c_DIVU) ? Val1 : Val2;
          acc_d        = '0;
          count_d      = 5'd31;
          state_d      = S_RUN;
        end
      end
      S_RUN: begin
        w_fsm_freeze = 1'b1;
        acc_d        = w_step_acc;
        opb_d        = w_step_opb;
        if (!is_div_q) opa_d = opa_q << 1;
        if (count_q == 5'd0) begin
          res_d   = is_div_q ? w_step_opb : w_step_acc;
          state_d = S_DONE;
        end else begin
          count_d = count_q - 5'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      res_q    <= '0;
      is_div_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      res_q    <= res_d;
      is_div_q <= is_div_d;
    end
  end

  // IDLE freeze is combinational on EXE_CMD, so reset must mask it directly
  assign freeze     = w_fsm_freeze & ~rst;
  assign ALU_result = (state_q == S_DONE) ? res_q : w_alu;
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;
  assign freeze         = 1'b0;
  assign ALU_result     = w_alu;
`endif

  assign MEM_R_EN = MEM_R_EN_in & ~freeze;
  assign MEM_W_EN = MEM_W_EN_in & ~freeze;
  assign WB_EN    = WB_EN_in & ~freeze;

endmodule

`default_nettype wire

// File: tb/tb_exe_stage.sv
// +-----------------------------------------------------------------------+
// | tb_exe_stage : randomized self-checking bench for exe_stage.          |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_exe_stage;

  logic        clk;
  logic        rst;
  logic [31:0] Val1, Val2, Reg2, PC_in;
  logic [1:0]  Br_type;
  logic [3:0]  EXE_CMD;
  logic [4:0]  Dest_in;
  logic        MEM_R_EN_in, MEM_W_EN_in, WB_EN_in;
  logic [31:0] ALU_result, Br_addr, Reg2_out;
  logic        Br_taken, freeze, MEM_R_EN, MEM_W_EN, WB_EN;
  logic [4:0]  Dest;

  int n_checks = 0;
  int n_fail   = 0;

  exe_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .Val1(Val1), .Val2(Val2), .Reg2(Reg2), .PC_in(PC_in),
    .Br_type(Br_type), .EXE_CMD(EXE_CMD), .Dest_in(Dest_in),
    .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in), .WB_EN_in(WB_EN_in),
    .ALU_result(ALU_result), .Br_addr(Br_addr), .Br_taken(Br_taken),
    .freeze(freeze), .Dest(Dest), .Reg2_out(Reg2_out),
    .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .WB_EN(WB_EN)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic from the operation table
  function automatic logic [31:0] ref_alu(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ext;
    int unsigned sh;
    sh  = b % 32;
    ext = {{32{a[31]}}, a};
    case (cmd)
      4'd0:  return a + b;
      4'd2:  return a - b;
      4'd4:  return a & b;
      4'd5:  return a | b;
      4'd6:  return ~(a | b);
      4'd7:  return a ^ b;
      4'd8:  return a * (32'd1 << sh);
      4'd9:  return ext[31+sh -: 32];
      4'd10: return a / (32'd1 << sh);
`ifdef EXE_MULDIV_EN
      4'd12: return a * b;
      4'd13: return (b == 0) ? 32'hFFFF_FFFF : a / b;
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_taken(input logic [3:0] cmd, input logic [1:0] bt,
                                     input logic [31:0] a, input logic [31:0] r2);
    if (cmd == 4'd12 || cmd == 4'd13) return 1'b0;
    return (bt == 2'd1 && a == 0) || (bt == 2'd2 && a != r2) || (bt == 2'd3);
  endfunction

  task automatic drive(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r2, input logic [31:0] pc, input logic [1:0] bt,
                       input logic [4:0] d, input logic mr, input logic mw, input logic wb);
    EXE_CMD = cmd; Val1 = a; Val2 = b; Reg2 = r2; PC_in = pc; Br_type = bt;
    Dest_in = d; MEM_R_EN_in = mr; MEM_W_EN_in = mw; WB_EN_in = wb;
  endtask

  // Full comparison of an unfrozen cycle against the model
  task automatic check_comb(input string tag);
    check({tag, "_alu"},    ALU_result, ref_alu(EXE_CMD, Val1, Val2));
    check({tag, "_taken"},  {31'd0, Br_taken}, {31'd0, ref_taken(EXE_CMD, Br_type, Val1, Reg2)});
    check({tag, "_braddr"}, Br_addr, PC_in + Val2 * 4);
    check({tag, "_freeze"}, {31'd0, freeze}, 32'd0);
    check({tag, "_pass"},   {Dest, Reg2_out[26:0]}, {Dest_in, Reg2[26:0]});
    check({tag, "_en"},     {29'd0, MEM_R_EN, MEM_W_EN, WB_EN},
                            {29'd0, MEM_R_EN_in, MEM_W_EN_in, WB_EN_in});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_alu"},  ALU_result, 32'd0);
    check({tag, "_br"},   Br_addr, 32'd0);
    check({tag, "_ctl"},  {25'd0, Br_taken, freeze, MEM_R_EN, MEM_W_EN, WB_EN, Dest[1:0]}, 32'd0);
    check({tag, "_pass"}, {27'd0, Dest} | Reg2_out, 32'd0);
  endtask

`ifdef EXE_MULDIV_EN
  task automatic run_md(input string tag, input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
    int  n;
    bit  done;
    logic [1:0] bt;
    bt = 2'($urandom_range(1, 3));
    @(posedge clk); #1;
    drive(cmd, a, b, $urandom, $urandom, bt, 5'($urandom), 1'b1, 1'b1, 1'b1);
    n = 0; done = 0;
    while (!done) begin
      @(negedge clk);
      if (freeze !== 1'b1) done = 1;
      else begin
        n++;
        check({tag, "_frz_en"}, {29'd0, MEM_R_EN, MEM_W_EN, WB_EN}, 32'd0);
        if (n > 100) begin
          check({tag, "_timeout"}, 32'd1, 32'd0);
          done = 1;
        end
      end
    end
    check({tag, "_cycles"}, n, 32'd33);
    check({tag, "_result"}, ALU_result, ref_alu(cmd, a, b));
    check({tag, "_done_en"}, {29'd0, MEM_R_EN, MEM_W_EN, WB_EN}, 32'd7);
    check({tag, "_done_taken"}, {31'd0, Br_taken}, 32'd0);
  endtask
`endif

  initial begin
    rst = 1'b1;
    drive(4'd0, 0, 0, 0, 0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #2;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed single-cycle cases
    @(posedge clk); #1;
    drive(4'd0, 32'h7FFF_FFFF, 32'd1, 0, 0, 2'd0, 5'd3, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("add_ovf", ALU_result, 32'h8000_0000);
    check("add_frz", {31'd0, freeze}, 32'd0);
    @(posedge clk); #1;
    drive(4'd9, 32'h8000_0000, 32'd4, 0, 0, 2'd0, 5'd3, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("sra", ALU_result, 32'hF800_0000);
    @(posedge clk); #1;
    drive(4'd2, 32'd5, 32'd3, 32'd5, 32'h100, 2'd2, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("bne_eq", {31'd0, Br_taken}, 32'd0);
    @(posedge clk); #1;
    Reg2 = 32'd6;
    @(negedge clk);
    check("bne_ne", {31'd0, Br_taken}, 32'd1);
    check("bne_addr", Br_addr, 32'h10C);
    @(posedge clk); #1;
    Br_type = 2'd3; Reg2 = 32'd5;
    @(negedge clk);
    check("jmp", {31'd0, Br_taken}, 32'd1);

    // Random single-cycle traffic
    for (int i = 0; i < 250; i++) begin
      logic [3:0]  cmd;
      logic [31:0] a;
      cmd = 4'($urandom_range(0, 15));
`ifdef EXE_MULDIV_EN
      if (cmd == 4'd12 || cmd == 4'd13) cmd = 4'd0;
`endif
      a = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      @(posedge clk); #1;
      drive(cmd, a, $urandom, ($urandom_range(0, 3) == 0) ? a : $urandom, $urandom,
            2'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      @(negedge clk);
      check_comb("rand");
    end

`ifdef EXE_MULDIV_EN
    run_md("mul_dir", 4'd12, 32'h0001_0003, 32'h0000_0005);
    run_md("divu_dir", 4'd13, 32'd100, 32'd7);
    run_md("divu_zero", 4'd13, $urandom, 32'd0);
    run_md("b2b_mul", 4'd12, $urandom, $urandom);
    run_md("b2b_divu", 4'd13, $urandom, 32'($urandom_range(1, 1000)));
    for (int i = 0; i < 6; i++) begin
      run_md("md_rand", (i % 2 == 0) ? 4'd12 : 4'd13, $urandom,
             (i == 3) ? $urandom : 32'($urandom_range(1, 65535)));
    end

    // Reset during RUN at count 10 (cycle 22)
    @(posedge clk); #1;
    drive(4'd12, $urandom, $urandom, 0, 0, 2'd0, 5'd1, 1'b1, 1'b1, 1'b1);
    repeat (23) @(negedge clk);
    check("pre_rst_freeze", {31'd0, freeze}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_freeze", {31'd0, freeze}, 32'd0);
    check("rst_alu", ALU_result, 32'd0);
    drive(4'd0, 0, 0, 0, 0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check_all_zero("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    run_md("mul_after_rst", 4'd12, 32'h0001_0003, 32'h0000_0005);
`else
    @(posedge clk); #1;
    drive(4'd12, 32'h0001_0003, 32'h0000_0005, 0, 0, 2'd3, 5'd7, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("nomd_freeze", {31'd0, freeze}, 32'd0);
      check("nomd_alu", ALU_result, 32'd0);
      check("nomd_en", {29'd0, MEM_R_EN, MEM_W_EN, WB_EN}, 32'd7);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
